// File: rtl/execute_out_buffer.sv
// Execute-stage output FIFO: holds up to DEPTH result bundles for memory/writeback.
// Define EXECUTE_OUT_BUFFER_BYPASS_EN to forward inputs combinationally when empty.
module execute_out_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 3,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enable_execute,
    input  logic [1:0]               W_Control_in,
    input  logic                     Mem_Control_in,
    input  logic [DATA_W-1:0]        aluin,
    input  logic [DATA_W-1:0]        pcin,
    input  logic [DATA_W-1:0]        IR_in,
    input  logic [DATA_W-1:0]        M_Data_in,
    input  logic [REG_W-1:0]         dr_in,
    input  logic [REG_W-1:0]         sr1_in,
    input  logic [REG_W-1:0]         sr2_in,
    input  logic [2:0]               NZP_in,
    output logic                     in_ready,
    output logic                     enable_execute_out,
    input  logic                     out_ready,
    output logic [1:0]               W_Control_out,
    output logic                     Mem_Control_out,
    output logic [DATA_W-1:0]        aluout,
    output logic [DATA_W-1:0]        pcout,
    output logic [REG_W-1:0]         dr,
    output logic [REG_W-1:0]         sr1,
    output logic [REG_W-1:0]         sr2,
    output logic [DATA_W-1:0]        IR_Exec,
    output logic [2:0]               NZP,
    output logic [DATA_W-1:0]        M_Data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned BUNDLE_W = 6 + 4 * DATA_W + 3 * REG_W;

    logic [BUNDLE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count_q;
    logic [BUNDLE_W-1:0] bundle_in;
    logic [BUNDLE_W-1:0] head;
    logic [BUNDLE_W-1:0] bundle_out;
    logic                head_valid;
    logic                out_valid;
    logic                push;
    logic                pop;

    assign bundle_in = {W_Control_in, Mem_Control_in, aluin, pcin, IR_in, M_Data_in,
                        dr_in, sr1_in, sr2_in, NZP_in};

    assign head_valid = (count_q != '0);
    // Registered count only, so out_ready never reaches in_ready combinationally.
    assign in_ready   = (count_q != CNT_W'(DEPTH));

`ifdef EXECUTE_OUT_BUFFER_BYPASS_EN
    assign out_valid = head_valid | (enable_execute & ~flush);
    assign head      = head_valid ? mem[rd_ptr] : bundle_in;
`else
    assign out_valid = head_valid;
    assign head      = mem[rd_ptr];
`endif

    assign bundle_out = out_valid ? head : '0;
    assign {W_Control_out, Mem_Control_out, aluout, pcout, IR_Exec, M_Data,
            dr, sr1, sr2, NZP} = bundle_out;

    assign enable_execute_out = out_valid;
    assign count              = count_q;

    assign push = enable_execute & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // A bypassed bundle is pushed and popped together, so it never occupies a slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage is never cleared; occupancy alone decides what is live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bundle_in;
        end
    end

endmodule

// File: tb/tb_execute_out_buffer.sv
// Bench for execute_out_buffer: vector table, hand sequences and a queue-based random model.
module tb_execute_out_buffer;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [1:0]  w;
        logic        m;
        logic [15:0] alu;
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] md;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  nzp;
    } bundle_t;

    typedef struct {
        bit          rst;
        bit          fl;
        bit          en;
        bit          ordy;
        logic [15:0] alu;
        logic [2:0]  drv;
        bit          ev;
        int          ec;
        logic [15:0] ealu;
        logic [2:0]  edr;
        bit          erdy;
    } vec_t;

    logic clock = 1'b0;
    logic reset, flush, enable_execute, out_ready;
    bundle_t din;
    bundle_t dout;
    logic in_ready, enable_execute_out;
    logic [CNT_W-1:0] count;
    logic [1:0] w_out;
    logic m_out;
    logic [15:0] alu_out, pc_out, ir_out, md_out;
    logic [2:0] dr_out, sr1_out, sr2_out, nzp_out;

    int n_cmp = 0;
    int n_fail = 0;
    bundle_t q[$];
    vec_t tv[21];

    always #5 clock = ~clock;

    execute_out_buffer #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .clock              (clock),
        .reset              (reset),
        .flush              (flush),
        .enable_execute     (enable_execute),
        .W_Control_in       (din.w),
        .Mem_Control_in     (din.m),
        .aluin              (din.alu),
        .pcin               (din.pc),
        .IR_in              (din.ir),
        .M_Data_in          (din.md),
        .dr_in              (din.dr),
        .sr1_in             (din.sr1),
        .sr2_in             (din.sr2),
        .NZP_in             (din.nzp),
        .in_ready           (in_ready),
        .enable_execute_out (enable_execute_out),
        .out_ready          (out_ready),
        .W_Control_out      (w_out),
        .Mem_Control_out    (m_out),
        .aluout             (alu_out),
        .pcout              (pc_out),
        .dr                 (dr_out),
        .sr1                (sr1_out),
        .sr2                (sr2_out),
        .IR_Exec            (ir_out),
        .NZP                (nzp_out),
        .M_Data             (md_out),
        .count              (count)
    );

    assign dout = '{w: w_out, m: m_out, alu: alu_out, pc: pc_out, ir: ir_out, md: md_out,
                    dr: dr_out, sr1: sr1_out, sr2: sr2_out, nzp: nzp_out};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit rst, bit fl, bit en, bit ordy, logic [15:0] alu,
                                logic [2:0] drv, bit ev, int ec, logic [15:0] ealu,
                                logic [2:0] edr, bit erdy);
        vec_t v;
        v.rst = rst; v.fl = fl; v.en = en; v.ordy = ordy; v.alu = alu; v.drv = drv;
        v.ev = ev; v.ec = ec; v.ealu = ealu; v.edr = edr; v.erdy = erdy;
        return v;
    endfunction

    // Expected outputs derived from the queue of held bundles and the current inputs.
    task automatic model_check(input string name);
        bit      ev;
        bundle_t eb;
        if (q.size() != 0) begin
            ev = 1'b1;
            eb = q[0];
        end else begin
`ifdef EXECUTE_OUT_BUFFER_BYPASS_EN
            ev = enable_execute && !flush;
            eb = ev ? din : '0;
`else
            ev = 1'b0;
            eb = '0;
`endif
        end
        check({name, "_valid"}, 128'(enable_execute_out), 128'(ev));
        check({name, "_ready"}, 128'(in_ready), 128'(q.size() != DEPTH));
        check({name, "_count"}, 128'(count), 128'(q.size()));
        check({name, "_bundle"}, 128'(dout), 128'(eb));
    endtask

    // Apply the current inputs to the queue model (called just before the clock edge).
    task automatic model_step();
        bit has, push, pop, byp;
        if (reset || flush) begin
            q.delete();
        end else begin
            has  = q.size() != 0;
            push = enable_execute && (q.size() != DEPTH);
            pop  = has && out_ready;
            byp  = 1'b0;
`ifdef EXECUTE_OUT_BUFFER_BYPASS_EN
            byp = !has && enable_execute && out_ready;
`endif
            if (!byp) begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(din);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; flush = 1'b0; enable_execute = 1'b0; out_ready = 1'b0; din = '0;
    endtask

    initial begin
        logic [95:0] r;

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        q.delete();
        // Reset state, sampled while reset is still asserted.
        #1;
        check("reset_valid", 128'(enable_execute_out), 128'(0));
        check("reset_ready", 128'(in_ready), 128'(1));
        check("reset_count", 128'(count), 128'(0));
        check("reset_bundle", 128'(dout), 128'(0));
        tick();

`ifndef EXECUTE_OUT_BUFFER_BYPASS_EN
        //            rst fl en rdy alu      dr  | ev cnt alu      dr  rdy
        tv[0]  = mk(0, 0, 1, 1, 16'h1234, 5, 0, 0, 16'h0000, 0, 1);
        tv[1]  = mk(0, 0, 0, 1, 16'h0000, 0, 1, 1, 16'h1234, 5, 1);
        tv[2]  = mk(0, 0, 0, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);
        tv[3]  = mk(0, 0, 1, 0, 16'h000a, 1, 0, 0, 16'h0000, 0, 1);
        tv[4]  = mk(0, 0, 1, 0, 16'h000b, 2, 1, 1, 16'h000a, 1, 1);
        tv[5]  = mk(0, 0, 1, 0, 16'h000c, 3, 1, 2, 16'h000a, 1, 0);
        tv[6]  = mk(0, 0, 1, 1, 16'h000c, 3, 1, 2, 16'h000a, 1, 0);
        tv[7]  = mk(0, 0, 1, 1, 16'h000c, 3, 1, 1, 16'h000b, 2, 1);
        tv[8]  = mk(0, 0, 0, 1, 16'h0000, 0, 1, 1, 16'h000c, 3, 1);
        tv[9]  = mk(0, 0, 0, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);
        tv[10] = mk(0, 0, 1, 0, 16'h0011, 1, 0, 0, 16'h0000, 0, 1);
        tv[11] = mk(0, 0, 1, 0, 16'h0022, 2, 1, 1, 16'h0011, 1, 1);
        tv[12] = mk(0, 1, 1, 1, 16'h0033, 3, 1, 2, 16'h0011, 1, 0);
        tv[13] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);
        tv[14] = mk(0, 1, 1, 0, 16'h0044, 4, 0, 0, 16'h0000, 0, 1);
        tv[15] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);
        tv[16] = mk(0, 0, 1, 0, 16'h0055, 5, 0, 0, 16'h0000, 0, 1);
        tv[17] = mk(0, 0, 1, 1, 16'h0066, 6, 1, 1, 16'h0055, 5, 1);
        tv[18] = mk(0, 0, 1, 0, 16'h0077, 7, 1, 1, 16'h0066, 6, 1);
        tv[19] = mk(1, 0, 0, 1, 16'h0000, 0, 1, 2, 16'h0066, 6, 0);
        tv[20] = mk(0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);
        for (int i = 0; i < 21; i++) begin
            idle_inputs();
            reset = tv[i].rst; flush = tv[i].fl; enable_execute = tv[i].en;
            out_ready = tv[i].ordy; din.alu = tv[i].alu; din.dr = tv[i].drv;
            #1;
            check($sformatf("vec%0d_valid", i), 128'(enable_execute_out), 128'(tv[i].ev));
            check($sformatf("vec%0d_count", i), 128'(count), 128'(tv[i].ec));
            check($sformatf("vec%0d_aluout", i), 128'(alu_out), 128'(tv[i].ealu));
            check($sformatf("vec%0d_dr", i), 128'(dr_out), 128'(tv[i].edr));
            check($sformatf("vec%0d_ready", i), 128'(in_ready), 128'(tv[i].erdy));
            model_step();
            tick();
        end
`else
        // Bypass: empty buffer forwards in the same cycle and does not store when consumed.
        idle_inputs();
        enable_execute = 1'b1; out_ready = 1'b1; din.ir = 16'h5020;
        #1;
        check("byp_valid", 128'(enable_execute_out), 128'(1));
        check("byp_ir", 128'(ir_out), 128'(16'h5020));
        model_step();
        tick();
        idle_inputs();
        #1;
        check("byp_count0", 128'(count), 128'(0));
        model_step();
        tick();
        enable_execute = 1'b1; out_ready = 1'b0; din.ir = 16'h5020;
        #1;
        check("byp_hold_ir", 128'(ir_out), 128'(16'h5020));
        model_step();
        tick();
        idle_inputs();
        #1;
        check("byp_count1", 128'(count), 128'(1));
        model_step();
        tick();
`endif

        // Streaming: one push and one pop per cycle with incrementing pcin.
        idle_inputs();
        reset = 1'b1;
        #1;
        model_step();
        tick();
        for (int i = 0; i <= 20; i++) begin
            idle_inputs();
            enable_execute = 1'b1; out_ready = 1'b1; din.pc = 16'(100 + i);
            #1;
            model_check($sformatf("stream%0d", i));
`ifndef EXECUTE_OUT_BUFFER_BYPASS_EN
            if (i > 0) begin
                check($sformatf("stream%0d_pc", i), 128'(pc_out), 128'(100 + i - 1));
                check($sformatf("stream%0d_cnt", i), 128'(count), 128'(1));
            end
`endif
            model_step();
            tick();
        end

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            din = r[$bits(bundle_t)-1:0];
            enable_execute = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 99) < 5);
            reset = ($urandom_range(0, 99) < 2);
            #1;
            model_check($sformatf("rand%0d", i));
            model_step();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
